// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines,
// uncached bypass, per-index flush and hit/miss counters.
module cache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_CPU,
  input  logic        Wr_CPU,
  input  logic [31:0] A_CPU,
  input  logic [31:0] Data_CPU_Wr,
  input  logic [1:0]  Ins_Type,
  output logic        Ready_Cache,
  output logic [31:0] Data_CPU_Rd,
  output logic        Req_Mem,
  output logic        Wr_Mem,
  output logic [31:0] A_Mem,
  output logic [31:0] Data_Mem_Wr,
  input  logic        Ready_Mem,
  input  logic [31:0] Data_Mem_Rd,
  output logic [31:0] Hit_Count,
  output logic [31:0] Miss_Count
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS;

  localparam logic [1:0] T_DATA   = 2'b00;
  localparam logic [1:0] T_INSTR  = 2'b01;
  localparam logic [1:0] T_BYPASS = 2'b10;
  localparam logic [1:0] T_FLUSH  = 2'b11;

  typedef enum logic [2:0] {IDLE, WB, FILL, BYPASS, RESP} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [LINES-1:0]        dirty;
  logic [TAG_W-1:0]        tags  [LINES];
  logic [31:0]             lines [LINES];

  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic                    wr;
  logic [1:0]              typ;

  logic [INDEX_BITS-1:0]   cpu_idx;
  logic [TAG_W-1:0]        cpu_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    cpu_wr;
  logic                    hit;
  logic                    victim_dirty;

  // Address split and tag compare for the incoming request and the latched one.
  always_comb begin
    cpu_idx      = A_CPU[INDEX_BITS-1:0];
    cpu_tag      = A_CPU[31:INDEX_BITS];
    req_idx      = addr[INDEX_BITS-1:0];
    req_tag      = addr[31:INDEX_BITS];
    cpu_wr       = Wr_CPU && (Ins_Type != T_INSTR);
    hit          = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    victim_dirty = valid[cpu_idx] && dirty[cpu_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      Ready_Cache <= 1'b0;
      Data_CPU_Rd <= '0;
      Req_Mem     <= 1'b0;
      Wr_Mem      <= 1'b0;
      A_Mem       <= '0;
      Data_Mem_Wr <= '0;
      Hit_Count   <= '0;
      Miss_Count  <= '0;
      addr        <= '0;
      wdata       <= '0;
      wr          <= 1'b0;
      typ         <= T_DATA;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req_CPU) begin
            addr  <= A_CPU;
            wdata <= Data_CPU_Wr;
            wr    <= cpu_wr;
            typ   <= Ins_Type;
            unique case (Ins_Type)
              T_DATA, T_INSTR: begin
                if (hit) begin
                  Hit_Count <= Hit_Count + 32'd1;
                  if (cpu_wr) begin
                    lines[cpu_idx] <= Data_CPU_Wr;
                    dirty[cpu_idx] <= 1'b1;
                  end else begin
                    Data_CPU_Rd <= lines[cpu_idx];
                  end
                  Ready_Cache <= 1'b1;
                  state       <= RESP;
                end else begin
                  Miss_Count <= Miss_Count + 32'd1;
                  if (victim_dirty) begin
                    Req_Mem     <= 1'b1;
                    Wr_Mem      <= 1'b1;
                    A_Mem       <= {tags[cpu_idx], cpu_idx};
                    Data_Mem_Wr <= lines[cpu_idx];
                    state       <= WB;
                  end else if (cpu_wr) begin
                    // One-word lines: a write miss allocates without a fill.
                    lines[cpu_idx] <= Data_CPU_Wr;
                    tags[cpu_idx]  <= cpu_tag;
                    valid[cpu_idx] <= 1'b1;
                    dirty[cpu_idx] <= 1'b1;
                    Ready_Cache    <= 1'b1;
                    state          <= RESP;
                  end else begin
                    Req_Mem <= 1'b1;
                    Wr_Mem  <= 1'b0;
                    A_Mem   <= A_CPU;
                    state   <= FILL;
                  end
                end
              end
              T_BYPASS: begin
                Req_Mem     <= 1'b1;
                Wr_Mem      <= Wr_CPU;
                A_Mem       <= A_CPU;
                Data_Mem_Wr <= Data_CPU_Wr;
                state       <= BYPASS;
              end
              default: begin
                if (victim_dirty) begin
                  Req_Mem     <= 1'b1;
                  Wr_Mem      <= 1'b1;
                  A_Mem       <= {tags[cpu_idx], cpu_idx};
                  Data_Mem_Wr <= lines[cpu_idx];
                  state       <= WB;
                end else begin
                  valid[cpu_idx] <= 1'b0;
                  dirty[cpu_idx] <= 1'b0;
                  Data_CPU_Rd    <= '0;
                  Ready_Cache    <= 1'b1;
                  state          <= RESP;
                end
              end
            endcase
          end
        end
        WB: begin
          if (Ready_Mem) begin
            Req_Mem <= 1'b0;
            if (typ == T_FLUSH) begin
              valid[req_idx] <= 1'b0;
              dirty[req_idx] <= 1'b0;
              Data_CPU_Rd    <= '0;
              Ready_Cache    <= 1'b1;
              state          <= RESP;
            end else if (wr) begin
              lines[req_idx] <= wdata;
              tags[req_idx]  <= req_tag;
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b1;
              Ready_Cache    <= 1'b1;
              state          <= RESP;
            end else begin
              // Fill address is set up now; FILL raises Req_Mem on the next edge.
              Wr_Mem <= 1'b0;
              A_Mem  <= addr;
              state  <= FILL;
            end
          end
        end
        FILL: begin
          if (!Req_Mem) begin
            Req_Mem <= 1'b1;
          end else if (Ready_Mem) begin
            Req_Mem        <= 1'b0;
            lines[req_idx] <= Data_Mem_Rd;
            tags[req_idx]  <= req_tag;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            Data_CPU_Rd    <= Data_Mem_Rd;
            Ready_Cache    <= 1'b1;
            state          <= RESP;
          end
        end
        BYPASS: begin
          if (Ready_Mem) begin
            Req_Mem     <= 1'b0;
            Data_CPU_Rd <= wr ? 32'd0 : Data_Mem_Rd;
            Ready_Cache <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          Ready_Cache <= 1'b0;
          Data_CPU_Rd <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl against a line-level cache and
// memory model, plus the directed scenarios and a mid-fill reset.
module tb_cache_ctrl;

  localparam int unsigned IB    = 4;
  localparam int unsigned NL    = 1 << IB;
  localparam int unsigned BOUND = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req_CPU;
  logic        Wr_CPU;
  logic [31:0] A_CPU;
  logic [31:0] Data_CPU_Wr;
  logic [1:0]  Ins_Type;
  logic        Ready_Cache;
  logic [31:0] Data_CPU_Rd;
  logic        Req_Mem;
  logic        Wr_Mem;
  logic [31:0] A_Mem;
  logic [31:0] Data_Mem_Wr;
  logic        Ready_Mem;
  logic [31:0] Data_Mem_Rd;
  logic [31:0] Hit_Count;
  logic [31:0] Miss_Count;

  cache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .Req_CPU(Req_CPU), .Wr_CPU(Wr_CPU), .A_CPU(A_CPU),
    .Data_CPU_Wr(Data_CPU_Wr), .Ins_Type(Ins_Type), .Ready_Cache(Ready_Cache),
    .Data_CPU_Rd(Data_CPU_Rd), .Req_Mem(Req_Mem), .Wr_Mem(Wr_Mem), .A_Mem(A_Mem),
    .Data_Mem_Wr(Data_Mem_Wr), .Ready_Mem(Ready_Mem), .Data_Mem_Rd(Data_Mem_Rd),
    .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference state: cache lines, counters and backing memory.
  logic        m_valid [NL];
  logic        m_dirty [NL];
  logic [31:0] m_addr  [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] m_hit;
  logic [31:0] m_miss;
  logic [31:0] mem [logic [31:0]];
  txn_t        mem_log [$];
  bit          hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hDEAD, a[15:0]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit  = '0;
    m_miss = '0;
  endfunction

  // Memory responder: random latency, logs every accepted transaction.
  initial begin
    Ready_Mem   = 1'b0;
    Data_Mem_Rd = '0;
    forever begin
      @(negedge clk);
      if (Req_Mem && !rst) begin
        int lat;
        lat = $urandom_range(0, 3);
        repeat (lat) @(negedge clk);
        while (hold) @(negedge clk);
        if (Req_Mem && !rst) begin
          txn_t t;
          t.w = Wr_Mem;
          t.a = A_Mem;
          t.d = Data_Mem_Wr;
          mem_log.push_back(t);
          if (Wr_Mem) begin
            mem[A_Mem]  = Data_Mem_Wr;
            Data_Mem_Rd = '0;
          end else begin
            Data_Mem_Rd = mem_rd(A_Mem);
          end
          Ready_Mem = 1'b1;
          @(negedge clk);
          Ready_Mem = 1'b0;
        end
      end
    end
  end

  // Issue one request, predict its effect from the model, and compare everything.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t);
    txn_t        exp_q [$];
    txn_t        x;
    int          i;
    logic        ew;
    logic        check_rd;
    logic [31:0] exp_rd;
    int          cyc;
    bit          seen;
    i        = int'(a[IB-1:0]);
    ew       = wr && (t == 2'b00);
    check_rd = 1'b0;
    exp_rd   = '0;
    if (t == 2'b10) begin
      x.w = wr; x.a = a; x.d = d;
      exp_q.push_back(x);
      if (!wr) begin check_rd = 1'b1; exp_rd = mem_rd(a); end
    end else if (t == 2'b11) begin
      if (m_valid[i] && m_dirty[i]) begin
        x.w = 1'b1; x.a = m_addr[i]; x.d = m_data[i];
        exp_q.push_back(x);
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      check_rd   = 1'b1;
    end else if (m_valid[i] && m_addr[i] == a) begin
      m_hit = m_hit + 32'd1;
      if (ew) begin m_data[i] = d; m_dirty[i] = 1'b1; end
      else begin check_rd = 1'b1; exp_rd = m_data[i]; end
    end else begin
      m_miss = m_miss + 32'd1;
      if (m_valid[i] && m_dirty[i]) begin
        x.w = 1'b1; x.a = m_addr[i]; x.d = m_data[i];
        exp_q.push_back(x);
      end
      m_valid[i] = 1'b1;
      m_addr[i]  = a;
      if (ew) begin
        m_data[i]  = d;
        m_dirty[i] = 1'b1;
      end else begin
        x.w = 1'b0; x.a = a; x.d = '0;
        exp_q.push_back(x);
        m_data[i]  = mem_rd(a);
        m_dirty[i] = 1'b0;
        check_rd   = 1'b1;
        exp_rd     = m_data[i];
      end
    end

    mem_log.delete();
    @(negedge clk);
    Req_CPU = 1'b1; Wr_CPU = wr; A_CPU = a; Data_CPU_Wr = d; Ins_Type = t;
    @(posedge clk);
    #1;
    Req_CPU = 1'b0;
    Wr_CPU = $urandom_range(0, 1); A_CPU = $urandom; Data_CPU_Wr = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (Ready_Cache) seen = 1'b1;
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (exp_q.size() == 0) check("ready_latency", 32'(cyc), 32'd1);
    if (check_rd) check("rd_data", Data_CPU_Rd, exp_rd);
    @(negedge clk);
    check("ready_pulse_end", 32'(Ready_Cache), 32'd0);
    check("mem_txn_count", 32'(mem_log.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < mem_log.size(); k++) begin
      check("mem_wr", 32'(mem_log[k].w), 32'(exp_q[k].w));
      check("mem_addr", mem_log[k].a, exp_q[k].a);
      if (exp_q[k].w) check("mem_wdata", mem_log[k].d, exp_q[k].d);
    end
    check("hit_count", Hit_Count, m_hit);
    check("miss_count", Miss_Count, m_miss);
  endtask

  initial begin
    int          cyc;
    int          pulses;
    logic [1:0]  t;
    int unsigned r;
    rst = 1'b1; Req_CPU = 1'b0; Wr_CPU = 1'b0; A_CPU = '0; Data_CPU_Wr = '0; Ins_Type = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(Ready_Cache), 32'd0);
    check("rst_req_mem", 32'(Req_Mem), 32'd0);
    check("rst_rd_data", Data_CPU_Rd, 32'd0);
    check("rst_hits", Hit_Count, 32'd0);
    check("rst_misses", Miss_Count, 32'd0);

    // Directed scenarios.
    do_req(1'b0, 32'h11, 32'h0, 2'b00);
    do_req(1'b0, 32'h11, 32'h0, 2'b00);
    check("dir_hits", Hit_Count, 32'd1);
    check("dir_misses", Miss_Count, 32'd1);
    do_req(1'b1, 32'h11, 32'h55, 2'b00);
    do_req(1'b0, 32'h21, 32'h0, 2'b00);
    do_req(1'b1, 32'h11, 32'h77, 2'b00);
    do_req(1'b1, 32'h32, 32'h40, 2'b00);
    do_req(1'b0, 32'h32, 32'h0, 2'b00);
    do_req(1'b0, 32'h11, 32'h0, 2'b10);
    do_req(1'b0, 32'h11, 32'h0, 2'b00);
    do_req(1'b0, 32'h02, 32'h0, 2'b11);
    do_req(1'b0, 32'h32, 32'h0, 2'b00);
    do_req(1'b1, 32'h45, 32'h99, 2'b01);

    // Random traffic over a small address pool so hits, conflicts and flushes recur.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      t = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, t);
    end

    // Reset while a fill is outstanding.
    hold = 1'b1;
    @(negedge clk);
    Req_CPU = 1'b1; Wr_CPU = 1'b0; A_CPU = 32'h1234_5678; Ins_Type = 2'b00;
    @(posedge clk);
    #1 Req_CPU = 1'b0;
    cyc = 0;
    while (!Req_Mem && cyc < BOUND) begin @(negedge clk); cyc++; end
    check("fill_req_mem", 32'(Req_Mem), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fill_req_mem", 32'(Req_Mem), 32'd0);
    check("rst_fill_ready", 32'(Ready_Cache), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (Ready_Cache || Req_Mem) pulses++; end
    check("rst_no_activity", 32'(pulses), 32'd0);
    check("rst_fill_hits", Hit_Count, 32'd0);
    check("rst_fill_misses", Miss_Count, 32'd0);
    model_reset();
    do_req(1'b0, 32'h32, 32'h0, 2'b00);
    do_req(1'b0, 32'h11, 32'h0, 2'b00);
    do_req(1'b0, 32'h11, 32'h0, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate data/instruction cache controller sitting directly downstream of the CPU request stage. It accepts one-word requests from the CPU, services hits from an internal line array, and on a miss performs a dirty-victim write-back and/or a line fill over a simple request/ready memory port. It also supports an uncached bypass and a per-index flush, and keeps hit and miss counters.

## Interface
- INDEX_BITS, 4, line index width; the cache holds 2^INDEX_BITS one-word (32-bit) lines.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Req_CPU  in  1  CPU request valid.
- Wr_CPU  in  1  1 = write, 0 = read.
- A_CPU  in  32  word address; index = A_CPU[INDEX_BITS-1:0], tag = A_CPU[31:INDEX_BITS].
- Data_CPU_Wr  in  32  CPU write data.
- Ins_Type  in  2  request type: 00 = cacheable data, 01 = instruction fetch (cacheable read, Wr_CPU ignored), 10 = uncached bypass, 11 = flush index.
- Ready_Cache  out  1  one-cycle completion pulse.
- Data_CPU_Rd  out  32  read data, valid while Ready_Cache = 1.
- Req_Mem  out  1  memory request.
- Wr_Mem  out  1  memory write (1) or read (0).
- A_Mem  out  32  memory word address.
- Data_Mem_Wr  out  32  memory write data.
- Ready_Mem  in  1  memory completion pulse.
- Data_Mem_Rd  in  32  memory read data, valid with Ready_Mem.
- Hit_Count  out  32  cacheable hits, wraps at 2^32.
- Miss_Count  out  32  cacheable misses, wraps at 2^32.

## Operation
- State machine states: IDLE, WB, FILL, BYPASS, RESP.
- IDLE: when Req_CPU = 1, latch A_CPU, Wr_CPU, Data_CPU_Wr and Ins_Type, and perform the tag compare on the same edge. A hit is valid[idx] && tag[idx] == tag.
- Cacheable read hit: go to RESP; Data_CPU_Rd = line data. Hit_Count +1.
- Cacheable write hit: write the line, set dirty, go to RESP. Hit_Count +1.
- Read miss: Miss_Count +1. If the victim is valid and dirty, go to WB, then FILL; otherwise go to FILL. FILL reads A_Mem = the request address, writes the line with valid = 1 and dirty = 0, returns the data, and goes to RESP.
- Write miss: Miss_Count +1. Lines are one word, so there is no fill. If the victim is dirty, go to WB first. Then write the line with valid = 1, dirty = 1, and go to RESP.
- WB: Req_Mem = 1, Wr_Mem = 1, A_Mem = {stored tag, idx}, Data_Mem_Wr = line data.
- Bypass (Ins_Type 10): BYPASS issues one memory access of the request's type to A_CPU. The array and counters are not touched, and no tag check is done; coherence is software's responsibility.
- Flush (Ins_Type 11): if the line at idx is valid and dirty, go to WB, then invalidate. If it is not dirty, invalidate directly. Then go to RESP. Data_CPU_Rd = 0. Counters are unchanged.
- RESP: Ready_Cache = 1 for exactly one cycle, then go to IDLE.
- Once a request is accepted, it always completes, even if Req_CPU drops.
- Memory handshake: Req_Mem, Wr_Mem, A_Mem and Data_Mem_Wr are held stable until Ready_Mem is sampled high. Req_Mem falls on that same edge. Ready_Mem is ignored while Req_Mem = 0.
- Reset values: all outputs 0, all valid and dirty bits 0, counters 0, state IDLE. Line data and tags are not reset.
- Reset in any state: IDLE on the next edge and Req_Mem = 0. Any in-flight memory transaction is abandoned and no Ready_Cache is issued.

## Timing
- Request accepted at edge N (IDLE with Req_CPU = 1).
- Hit, clean write miss, or clean flush: Ready_Cache high during cycle N+1.
- Miss, bypass, or dirty flush: Req_Mem rises in cycle N+1.
  - Each memory phase ends on the edge where Ready_Mem = 1.
  - A following phase (FILL after WB) raises Req_Mem in the very next cycle.
  - Ready_Cache follows in the cycle after the last Ready_Mem edge.
- Fill and bypass read data is captured on the Ready_Mem edge.
- The earliest next acceptance is the edge at the end of the Ready_Cache cycle, since IDLE follows RESP. Maximum throughput is therefore one hit per 2 cycles.
- Only one memory phase is ever outstanding at a time.

## Test plan
- Reset, then read 0x11: Req_Mem read with A_Mem = 0x11; memory returns 0xDEAD0011; Ready_Cache with 0xDEAD0011. Re-read 0x11: Ready_Cache at N+1 with no Req_Mem. Hit_Count = 1, Miss_Count = 1.
- Write 0x11 with 0x55 (hit, dirty), then read 0x21 (same index): WB to A_Mem = 0x11 with data 0x55, then FILL read of 0x21. Miss_Count increments.
- Write miss to 0x32 with 0x40 into an invalid line: no Req_Mem, Ready_Cache at N+1. Reading 0x32 then hits and returns 0x40.
- Bypass read of 0x11 while it is cached dirty: memory read of 0x11, Ready_Cache returns the memory data. A later cacheable read of 0x11 still returns the cached value. Counters are unchanged.
- Flush with A_CPU = 0x02 after the 0x32 write: WB to A_Mem = 0x32 with data 0x40, then Ready_Cache. A re-read of 0x32 misses.
- Assert rst during FILL while Req_Mem = 1: Req_Mem = 0 the next cycle, no Ready_Cache, all lines invalid, counters 0.
